// File: rtl/seq_checker.sv
// seq_checker: locks onto an incrementing 0..MAX_VAL count stream and
// reports every deviation once locked, with saturating debug counters.
module seq_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 254,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned LOSS_N  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [15:0]      err_count,
  output logic [15:0]      word_count,
  output logic [7:0]       wrap_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_N + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_N + 1);
  localparam logic [WIDTH-1:0]  MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [RUN_W-1:0]  LOCK_W = RUN_W'(LOCK_N);
  localparam logic [MISS_W-1:0] LOSS_W = MISS_W'(LOSS_N);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  expected, expected_next;
  logic [RUN_W-1:0]  run, run_next;
  logic [MISS_W-1:0] miss, miss_next;
  logic              match;
  logic              hit, miss_ev, wrap_ev;

  // Successor in the count sequence; anything at or above MAX_VAL wraps to 0.
  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
    return (v >= MAX_W) ? '0 : v + WIDTH'(1);
  endfunction

  // Out-of-range data can never match, even if expected were corrupted.
  assign match = (in_data == expected) && (in_data <= MAX_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Next-state, tracking registers and per-sample events.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    run_next      = run;
    miss_next     = miss;
    hit           = 1'b0;
    miss_ev       = 1'b0;
    wrap_ev       = 1'b0;
    if (in_valid) begin
      expected_next = next_val(in_data);
      unique case (state)
        HUNT: begin
          run_next   = RUN_W'(1);
          state_next = SYNC;
        end
        SYNC: begin
          if (in_data == expected) begin
            run_next = run + RUN_W'(1);
            if (run_next == LOCK_W) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else begin
            run_next = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            hit       = 1'b1;
            wrap_ev   = (in_data == '0);
            miss_next = '0;
          end else begin
            miss_ev   = 1'b1;
            miss_next = miss + MISS_W'(1);
            if (miss_next == LOSS_W) state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Tracking registers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected  <= '0;
      run       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      expected  <= expected_next;
      run       <= run_next;
      miss      <= miss_next;
      locked    <= (state_next == LOCKED);
      err_pulse <= miss_ev;
    end
  end

  // Saturating debug counters and sticky error; clear overrides any event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      wrap_count <= '0;
    end else if (clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      wrap_count <= '0;
    end else begin
      if (miss_ev) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end
      if (hit && (word_count != '1)) word_count <= word_count + 16'd1;
      if (wrap_ev && (wrap_count != '1)) wrap_count <= wrap_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a behavioural reference model.
module tb_seq_checker;

  localparam int MAXV  = 254;
  localparam int LOCKN = 4;
  localparam int LOSSN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear;
  logic        locked, err_pulse, err_sticky;
  logic [15:0] err_count, word_count;
  logic [7:0]  wrap_count;

  int checks = 0;
  int errors = 0;
  bit run_on = 1'b0;

  seq_checker #(.WIDTH(8), .MAX_VAL(MAXV), .LOCK_N(LOCKN), .LOSS_N(LOSSN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .word_count(word_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = hunting, 1 = building a run, 2 = locked.
  int mode = 0, m_exp = 0, m_run = 0, m_miss = 0;
  int m_err = 0, m_word = 0, m_wrap = 0;
  bit m_locked = 0, m_pulse = 0, m_sticky = 0;

  function automatic int succ(input int v);
    return (v >= MAXV) ? 0 : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; m_exp = 0; m_run = 0; m_miss = 0;
      m_err = 0; m_word = 0; m_wrap = 0;
      m_locked = 0; m_pulse = 0; m_sticky = 0;
    end else begin
      int d;
      bit good, bad, wrp;
      d = int'(in_data);
      good = 0; bad = 0; wrp = 0;
      if (in_valid) begin
        if (mode == 0) begin
          m_run = 1; mode = 1;
        end else if (mode == 1) begin
          if (d == m_exp) begin
            m_run++;
            if (m_run >= LOCKN) begin mode = 2; m_miss = 0; end
          end else m_run = 1;
        end else begin
          if (d == m_exp && d <= MAXV) begin
            good = 1; wrp = (d == 0); m_miss = 0;
          end else begin
            bad = 1; m_miss++;
            if (m_miss >= LOSSN) mode = 0;
          end
        end
        m_exp = succ(d);
      end
      m_pulse  = bad;
      m_locked = (mode == 2);
      if (clear) begin
        m_err = 0; m_word = 0; m_wrap = 0; m_sticky = 0;
      end else begin
        if (bad) begin m_sticky = 1; if (m_err < 65535) m_err++; end
        if (good && m_word < 65535) m_word++;
        if (wrp && m_wrap < 255) m_wrap++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_on) begin
      chk("cmp_locked", int'(locked), int'(m_locked));
      chk("cmp_err_pulse", int'(err_pulse), int'(m_pulse));
      chk("cmp_err_sticky", int'(err_sticky), int'(m_sticky));
      chk("cmp_err_count", int'(err_count), m_err);
      chk("cmp_word_count", int'(word_count), m_word);
      chk("cmp_wrap_count", int'(wrap_count), m_wrap);
    end
  end

  // Drive one sample, wait for its sampling edge, settle.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_pulse"}, int'(err_pulse), 0);
    chk({tag, "_sticky"}, int'(err_sticky), 0);
    chk({tag, "_errc"}, int'(err_count), 0);
    chk({tag, "_wordc"}, int'(word_count), 0);
    chk({tag, "_wrapc"}, int'(wrap_count), 0);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk_all_zero("reset");
    rst = 1'b0;
    run_on = 1'b1;
    cyc(0, 8'd0, 0);

    // Lock on 10..13; 13 is still a SYNC sample and is not counted.
    cyc(1, 8'd10, 0); cyc(1, 8'd11, 0); cyc(1, 8'd12, 0);
    chk("lock_early", int'(locked), 0);
    cyc(1, 8'd13, 0);
    chk("lock_rise", int'(locked), 1);
    chk("lock_word0", int'(word_count), 0);
    chk("lock_err0", int'(err_count), 0);
    cyc(1, 8'd14, 0);
    chk("lock_word1", int'(word_count), 1);

    // Run up to the wrap: 15..251 adds 237 words, then 252,253,254,0,1.
    for (int v = 15; v <= 251; v++) cyc(1, 8'(v), 0);
    chk("pre_wrap_word", int'(word_count), 238);
    cyc(1, 8'd252, 0); cyc(1, 8'd253, 0); cyc(1, 8'd254, 0);
    cyc(1, 8'd0, 0);
    chk("wrap_count", int'(wrap_count), 1);
    cyc(1, 8'd1, 0);
    chk("wrap_word", int'(word_count), 243);
    chk("wrap_err", int'(err_count), 0);

    // Single error with resync.
    for (int v = 2; v <= 21; v++) cyc(1, 8'(v), 0);
    cyc(1, 8'd99, 0);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_errc", int'(err_count), 1);
    chk("single_sticky", int'(err_sticky), 1);
    cyc(1, 8'd100, 0);
    chk("single_pulse_gone", int'(err_pulse), 0);
    cyc(1, 8'd101, 0);
    chk("single_locked", int'(locked), 1);
    chk("single_word", int'(word_count), 265);

    // Loss of lock after three consecutive misses, then relock.
    cyc(0, 8'd0, 1);
    chk("clr_errc", int'(err_count), 0);
    chk("clr_sticky", int'(err_sticky), 0);
    cyc(1, 8'd50, 0); cyc(1, 8'd7, 0);
    chk("loss_held", int'(locked), 1);
    cyc(1, 8'd7, 0);
    chk("loss_pulse3", int'(err_pulse), 1);
    chk("loss_drop", int'(locked), 0);
    chk("loss_errc", int'(err_count), 3);
    cyc(1, 8'd7, 0);
    chk("loss_seed_nopulse", int'(err_pulse), 0);
    cyc(1, 8'd0, 0); cyc(1, 8'd1, 0); cyc(1, 8'd2, 0);
    chk("relock_early", int'(locked), 0);
    cyc(1, 8'd3, 0);
    chk("relock", int'(locked), 1);

    // Gaps inside a locked run.
    cyc(1, 8'd4, 0); cyc(0, 8'd0, 0); cyc(1, 8'd5, 0);
    cyc(0, 8'd77, 0); cyc(0, 8'd0, 0); cyc(1, 8'd6, 0); cyc(1, 8'd7, 0);
    chk("gap_word", int'(word_count), 4);
    chk("gap_err", int'(err_count), 3);

    // Clear in the same cycle as a mismatch: clear wins, pulse still fires.
    cyc(1, 8'd99, 1);
    chk("clrmis_pulse", int'(err_pulse), 1);
    chk("clrmis_errc", int'(err_count), 0);
    chk("clrmis_sticky", int'(err_sticky), 0);
    cyc(1, 8'd100, 0);
    chk("clrmis_word", int'(word_count), 1);

    // Out-of-range sample is an error; resync lands on 0.
    cyc(1, 8'd255, 0);
    chk("oor_errc", int'(err_count), 1);
    chk("oor_sticky", int'(err_sticky), 1);
    cyc(1, 8'd0, 0);
    chk("oor_wrap", int'(wrap_count), 1);

    // Saturation of word and wrap counters.
    cyc(0, 8'd0, 1);
    d = 8'd1;
    for (int i = 0; i < 65540; i++) begin
      cyc(1, d, 0);
      d = (d >= 8'(MAXV)) ? 8'd0 : d + 8'd1;
    end
    chk("sat_word", int'(word_count), 65535);
    chk("sat_wrap", int'(wrap_count), 255);
    chk("sat_err", int'(err_count), 0);

    // Asynchronous reset mid-run, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #2 rst = 1'b0;
    cyc(1, 8'd40, 0); cyc(1, 8'd41, 0); cyc(1, 8'd42, 0);
    chk("post_rst_early", int'(locked), 0);
    cyc(1, 8'd43, 0);
    chk("post_rst_lock", int'(locked), 1);
    chk("post_rst_word", int'(word_count), 0);
    cyc(0, 8'd0, 0);

    run_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the 8-bit incrementing count stream our pattern generator drives (0, 1, … 254, then back to 0). It samples a data/valid pair each `clk`, locks onto the sequence, and then reports every deviation. Error and throughput counters are kept for bench and board debug. It sits at the sink end of any datapath under test that carries the generator's pattern.

## Interface
Parameters:
- `WIDTH`, 8: data width.
- `MAX_VAL`, 254: last value before the sequence wraps to 0.
- `LOCK_N`, 4: consecutive correct samples, seed included, required to lock.
- `LOSS_N`, 3: consecutive mismatches while locked that drop lock.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in `WIDTH`: received sample.
- `clear` in 1: synchronous clear of all counters and `err_sticky`.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatch while locked.
- `err_sticky` out 1: set on the first error; held until `clear` or `rst`.
- `err_count` out 16: mismatches while locked; saturates at 0xFFFF.
- `word_count` out 16: matching samples while locked; saturates.
- `wrap_count` out 8: matched MAX_VAL→0 transitions while locked; saturates.

## Operation
- `next(v)` = 0 if v >= MAX_VAL, else v+1. Compute it at `WIDTH` bits with no overflow.
- Internal state: `expected` (WIDTH bits), `run` (match counter), `miss` (consecutive-miss counter), and a 3-state FSM.
- HUNT (reset state). On the first valid sample: `expected`<=next(d), `run`<=1, go to SYNC.
- SYNC, valid sample:
  - d==`expected`: `run`++ and `expected`<=next(d). When `run` reaches LOCK_N, go to LOCKED with `miss`<=0.
  - d!=`expected`: reseed with `expected`<=next(d), `run`<=1, stay in SYNC. Do not count an error.
- LOCKED, valid sample:
  - Match: `word_count`++, `miss`<=0, `expected`<=next(d). Also `wrap_count`++ if d==0.
  - Mismatch: `err_pulse`, `err_sticky`<=1, `err_count`++, `miss`++, and resync with `expected`<=next(d).
  - If `miss` reaches LOSS_N, go to HUNT. The mismatch that causes the drop is still counted.
- `in_data` > MAX_VAL while locked is always a mismatch.
- `in_valid`=0 freezes all state and counters. Gaps of any length are legal.
- `clear` affects only `err_count`, `word_count`, `wrap_count` and `err_sticky`; the FSM is untouched. If `clear` and a counting event occur in the same cycle, `clear` wins and the event is discarded.
- `rst` mid-operation:
  - All outputs and counters go to 0, the FSM to HUNT, `expected` to 0, immediately (asynchronously).
  - The first valid sample after deassertion is treated as a seed.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err_pulse`=0, `err_sticky`=0, all counts 0.
- `err_pulse` is high in the cycle after the edge that sampled the offending data. It lasts exactly 1 cycle per mismatch; back-to-back mismatches give back-to-back pulses.
- `locked` rises in the cycle after the edge that sampled the LOCK_N-th correct sample. It falls in the cycle after the edge that sampled the LOSS_N-th consecutive miss. `err_pulse` and the `locked` fall occur in the same cycle.
- Counter updates are visible one cycle after the sampling edge.
- Throughput: one sample per clock. No backpressure.

## Test plan
- Lock: after reset, drive 10,11,12,13 with `in_valid`=1 → `locked`=1 one cycle after 13 is sampled. During that run `err_count`=0 and `word_count`=0; after one more sample of 14, `word_count`=1.
- Wrap: locked, drive 252,253,254,0,1 → no `err_pulse`, `wrap_count`=1, `word_count` +5.
- Single error/resync: locked, drive 20,21,99,100,101 → exactly one `err_pulse` (after 99), `err_count`=1, `err_sticky`=1, `locked` stays 1.
- Loss: locked, drive 50,7,7,7 → three pulses, `err_count`=3, and `locked`=0 in the same cycle as the third pulse. A following 0,1,2,3 relocks.
- Gaps, clear, reset:
  - Interleave `in_valid`=0 cycles inside a locked run → no errors.
  - Assert `clear` in the same cycle as a mismatch sample → `err_count`=0, `err_sticky`=0 afterwards.
  - Assert `rst` mid-run → all outputs 0 without waiting for a clock edge.
- Out-of-range and saturation:
  - Locked, `in_data`=255 → counted as an error.
  - Force 65536 matches → `word_count` holds at 0xFFFF.
